y86_fetch_queue: RTL and testbench

//  Parametrised Y86-64 fetch front end: fetches FETCH_W-byte beats from instruction memory into a

---
 rtl/y86_fetch_queue_pkg.sv | 40 ++++
 rtl/y86_fetch_queue_instr_len.sv | 25 ++
 rtl/y86_fetch_queue.sv | 194 +++++++++++++++++++
 tb/tb_y86_fetch_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_fetch_queue_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status encoding, FSM states.
// Also holds the status-priority helper used when an instruction is split off the queue.
package y86_fetch_queue_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } fsm_e;

  // Memory error outranks an invalid opcode, which outranks halt.
  function automatic stat_e stat_of(input logic err, input logic invalid, input logic [3:0] icode);
    if (err)                 return STAT_ADR;
    else if (invalid)        return STAT_INS;
    else if (icode == I_HALT) return STAT_HLT;
    return STAT_AOK;
  endfunction

endpackage

// File: rtl/y86_fetch_queue_instr_len.sv
// Combinational length decode of a Y86-64 opcode byte's icode nibble.
// Invalid opcodes report length 1 with no register or constant bytes.
module y86_instr_len
  import y86_fetch_queue_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       need_regids_o,
  output logic       need_valc_o,
  output logic       invalid_o,
  output logic [3:0] len_o
);

  always_comb begin
    invalid_o     = (icode_i > I_POPQ);
    need_regids_o = 1'b0;
    need_valc_o   = 1'b0;
    if (!invalid_o) begin
      need_regids_o = icode_i inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                      I_OPQ, I_PUSHQ, I_POPQ};
      need_valc_o   = icode_i inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    end
    len_o = 4'd1 + {3'd0, need_regids_o} + (need_valc_o ? 4'd8 : 4'd0);
  end

endmodule

// File: rtl/y86_fetch_queue.sv
// Y86-64 fetch front end: imem beats fill a byte queue, whole instructions are split off
// into a registered ready/valid output slot. Redirect flushes and restarts fetch.
//
// Output handshake: instr_valid rises with every field stable and stays so until the
// cycle where instr_valid && instr_ready (a transfer); a new instruction may be loaded
// in that same cycle. redirect_valid overrides any transfer in its cycle.
module y86_fetch_queue
  import y86_fetch_queue_pkg::*;
#(
  parameter int          FETCH_W  = 8,
  parameter int          DEPTH    = 16,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  output logic                 mem_req,
  output logic [63:0]          mem_addr,
  input  logic                 mem_rsp_valid,
  input  logic [8*FETCH_W-1:0] mem_rsp_data,
  input  logic                 mem_rsp_err,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [3:0]           icode,
  output logic [3:0]           ifun,
  output logic [3:0]           rA,
  output logic [3:0]           rB,
  output logic [63:0]          valC,
  output logic [63:0]          valP,
  output logic [1:0]           stat,
  output logic                 dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    q_data [DEPTH];
  logic          q_err  [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [63:0]   fetch_pc_q, dec_pc_q;
  logic          epoch_q, req_epoch_q, outst_q;
  logic          mem_req_q;
  logic [63:0]   mem_addr_q;
  fsm_e          state_q;

  logic          valid_q;
  logic [3:0]    icode_q, ifun_q, ra_q, rb_q;
  logic [63:0]   valc_q, valp_q;
  logic [1:0]    stat_q;

  logic [7:0]    hb0, hb1;
  logic          need_regids, need_valc, invalid;
  logic [3:0]    len;
  logic          head_err, have_len, can_split, split_go, push, can_issue;
  logic [3:0]    pop_len;
  logic          cons_err;
  logic [63:0]   valc_raw;
  stat_e         split_stat;

  assign hb0 = q_data[rd_ptr_q];
  assign hb1 = q_data[rd_ptr_q + PW'(1)];

  y86_instr_len u_len (
    .icode_i       (hb0[7:4]),
    .need_regids_o (need_regids),
    .need_valc_o   (need_valc),
    .invalid_o     (invalid),
    .len_o         (len)
  );

  // An errored head byte is emitted at once so a bad beat cannot stall waiting for more bytes.
  assign head_err  = (count_q != '0) && q_err[rd_ptr_q];
  assign have_len  = (count_q >= CW'(len));
  assign can_split = have_len || head_err;
  assign pop_len   = have_len ? len : 4'd1;
  assign split_go  = (state_q == ST_RUN) && !redirect_valid && can_split &&
                     (!valid_q || instr_ready);
  assign push      = mem_rsp_valid && outst_q && (req_epoch_q == epoch_q) && !redirect_valid;
  assign can_issue = (state_q == ST_RUN) && !outst_q &&
                     (count_q <= CW'(DEPTH - FETCH_W));

  always_comb begin
    cons_err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < int'(pop_len)) cons_err = cons_err | q_err[rd_ptr_q + PW'(i)];
    end
  end

  always_comb begin
    valc_raw = '0;
    for (int k = 0; k < 8; k++) begin
      valc_raw[8*k +: 8] = q_data[rd_ptr_q + PW'(1) + PW'(need_regids) + PW'(k)];
    end
  end

  assign split_stat = stat_of(cons_err, invalid, hb0[7:4]);

  always_comb begin
    count_d = count_q;
    if (push)     count_d = count_d + CW'(FETCH_W);
    if (split_go) count_d = count_d - CW'(pop_len);
  end

  // Queue storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int j = 0; j < FETCH_W; j++) begin
        q_data[wr_ptr_q + PW'(j)] <= mem_rsp_data[8*j +: 8];
        q_err[wr_ptr_q + PW'(j)]  <= mem_rsp_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fetch_pc_q  <= RESET_PC;
      dec_pc_q    <= RESET_PC;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      outst_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      state_q     <= ST_RUN;
      valid_q     <= 1'b0;
      icode_q     <= '0;
      ifun_q      <= '0;
      ra_q        <= REG_NONE;
      rb_q        <= REG_NONE;
      valc_q      <= '0;
      valp_q      <= '0;
      stat_q      <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= redirect_pc;
      dec_pc_q   <= redirect_pc;
      epoch_q    <= ~epoch_q;
      mem_req_q  <= 1'b0;
      state_q    <= ST_RUN;
      valid_q    <= 1'b0;
      // A response landing now belongs to the old stream; the slot frees either way.
      if (mem_rsp_valid) outst_q <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      count_q   <= count_d;
      if (mem_rsp_valid && outst_q) outst_q <= 1'b0;
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + PW'(FETCH_W);
        fetch_pc_q <= fetch_pc_q + 64'(FETCH_W);
      end
      if (can_issue) begin
        mem_req_q   <= 1'b1;
        mem_addr_q  <= fetch_pc_q;
        outst_q     <= 1'b1;
        req_epoch_q <= epoch_q;
      end
      if (split_go) begin
        valid_q  <= 1'b1;
        icode_q  <= (split_stat == STAT_ADR) ? 4'h0 : hb0[7:4];
        ifun_q   <= hb0[3:0];
        ra_q     <= need_regids ? hb1[7:4] : REG_NONE;
        rb_q     <= need_regids ? hb1[3:0] : REG_NONE;
        valc_q   <= need_valc ? valc_raw : 64'h0;
        valp_q   <= dec_pc_q + 64'(pop_len);
        stat_q   <= split_stat;
        dec_pc_q <= dec_pc_q + 64'(pop_len);
        rd_ptr_q <= rd_ptr_q + PW'(pop_len);
        if (split_stat != STAT_AOK) state_q <= ST_STOP;
      end else if (instr_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = valid_q;
  assign icode       = icode_q;
  assign ifun        = ifun_q;
  assign rA          = ra_q;
  assign rB          = rb_q;
  assign valC        = valc_q;
  assign valP        = valp_q;
  assign stat        = stat_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_y86_fetch_queue.sv
// Bench for y86_fetch_queue: behavioural imem with random latency, random consumer
// back-pressure and a queue of expected decoded instructions.
module tb_y86_fetch_queue;
  import y86_fetch_queue_pkg::*;

  localparam int FETCH_W = 8;
  localparam int DEPTH   = 16;
  localparam int W       = 146;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 redirect_valid = 1'b0;
  logic [63:0]          redirect_pc = '0;
  logic                 mem_req;
  logic [63:0]          mem_addr;
  logic                 mem_rsp_valid = 1'b0;
  logic [8*FETCH_W-1:0] mem_rsp_data = '0;
  logic                 mem_rsp_err = 1'b0;
  logic                 instr_valid;
  logic                 instr_ready = 1'b0;
  logic [3:0]           icode, ifun, rA, rB;
  logic [63:0]          valC, valP;
  logic [1:0]           stat;
  logic                 dbg_state;

  y86_fetch_queue #(.FETCH_W(FETCH_W), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .stat(stat), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  logic [7:0]   bmem [1024];
  logic         err_en = 1'b0;
  logic [63:0]  err_addr = '0;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic         stall = 1'b0;
  int           extra_dly = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [1:0] st, input logic [3:0] ic,
      input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
      input logic [63:0] vc, input logic [63:0] vp);
    return {st, ic, fn, ra, rb, vc, vp};
  endfunction

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    return bmem[10'(a)];
  endfunction

  function automatic logic byte_err(input logic [63:0] a);
    return err_en && (a >= err_addr) && (a < err_addr + 64'(FETCH_W));
  endfunction

  function automatic void needs(input logic [3:0] ic, output logic regs, output logic vc);
    regs = 1'b0;
    vc   = 1'b0;
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: regs = 1'b1;
      4'h3, 4'h4, 4'h5:       begin regs = 1'b1; vc = 1'b1; end
      4'h7, 4'h8:             vc = 1'b1;
      default: ;
    endcase
  endfunction

  // Reference decode of the instruction at pc in bench memory.
  function automatic logic [W-1:0] ref_instr(input logic [63:0] pc, output logic [63:0] npc,
                                             output logic [1:0] st);
    logic [7:0]  b0, b1;
    logic        regs, vc, bad;
    logic [3:0]  ic, ra, rb;
    logic [63:0] c;
    int          n;
    b0 = rd_byte(pc);
    ic = b0[7:4];
    needs(ic, regs, vc);
    n = 1 + (regs ? 1 : 0) + (vc ? 8 : 0);
    bad = 1'b0;
    for (int i = 0; i < n; i++) bad |= byte_err(pc + 64'(i));
    ra = 4'hF;
    rb = 4'hF;
    if (regs) begin
      b1 = rd_byte(pc + 64'd1);
      ra = b1[7:4];
      rb = b1[3:0];
    end
    c = '0;
    if (vc) for (int k = 0; k < 8; k++) c[8*k +: 8] = rd_byte(pc + 64'(1 + (regs ? 1 : 0) + k));
    st = bad ? 2'd2 : (ic > 4'hB) ? 2'd3 : (ic == 4'h0) ? 2'd1 : 2'd0;
    if (bad) ic = 4'h0;
    npc = pc + 64'(n);
    return pack(st, ic, b0[3:0], ra, rb, c, npc);
  endfunction

  task automatic push_stream(input logic [63:0] start);
    logic [63:0] pc, npc;
    logic [1:0]  st;
    pc = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(ref_instr(pc, npc, st));
      if (st != 2'd0) break;
      pc = npc;
    end
  endtask

  task automatic gen_random(input logic [63:0] base, input int n);
    logic [63:0] a;
    logic [3:0]  ic;
    logic        regs, vc;
    a = base;
    for (int i = 0; i < n; i++) begin
      ic = 4'($urandom_range(1, 11));
      needs(ic, regs, vc);
      bmem[10'(a)] = {ic, 4'($urandom_range(0, 6))};
      a++;
      if (regs) begin bmem[10'(a)] = 8'($urandom); a++; end
      if (vc) for (int k = 0; k < 8; k++) begin bmem[10'(a)] = 8'($urandom); a++; end
    end
    bmem[10'(a)] = 8'h00;
  endtask

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    instr_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  logic        pend = 1'b0;
  logic [63:0] paddr = '0;
  int          dly = 0;
  always @(posedge clk) begin
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (pend) begin
      if (dly == 0) begin
        mem_rsp_valid = 1'b1;
        for (int j = 0; j < FETCH_W; j++) mem_rsp_data[8*j +: 8] = rd_byte(paddr + 64'(j));
        mem_rsp_err = err_en && (paddr == err_addr);
        pend = 1'b0;
      end else begin
        dly--;
      end
    end else if (mem_req) begin
      pend  = 1'b1;
      paddr = mem_addr;
      dly   = $urandom_range(0, 2) + extra_dly;
    end
  end

  task automatic redirect_raw(input logic [63:0] pc);
    @(posedge clk);
    #2;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    exp_q.delete();
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    @(posedge clk);
    #2;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    exp_q.delete();
    push_stream(pc);
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
  endtask

  task automatic push_test1();
    exp_q.push_back(pack(2'd0, 4'h3, 4'h0, 4'hF, 4'h4, 64'h0123456789ABCDEF, 64'd10));
    exp_q.push_back(pack(2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd11));
    exp_q.push_back(pack(2'd1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd12));
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && !redirect_valid && instr_valid) begin
      if (exp_q.size() == 0) begin
        check_val("extra_instr", W'(instr_valid), '0);
      end else begin
        check_val("instr", {stat, icode, ifun, rA, rB, valC, valP}, exp_q[0]);
        if (instr_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_val(tag, W'(exp_q.size()), '0);
  endtask

  task automatic expect_no_req(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check_val(tag, W'(cnt), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_fields"}, {stat, icode, ifun, rA, rB, valC, valP},
              pack(2'd0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0));
    check_val({tag, "_valid"}, W'(instr_valid), '0);
    check_val({tag, "_req"}, W'(mem_req), '0);
    check_val({tag, "_addr"}, W'(mem_addr), '0);
    check_val({tag, "_state"}, W'(dbg_state), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < 1024; i++) bmem[i] = 8'h00;
    begin
      logic [7:0] p1 [12];
      p1 = '{8'h30, 8'hF4, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h10, 8'h00};
      for (int i = 0; i < 12; i++) bmem[i] = p1[i];
    end
    for (int i = 0; i < 20; i++) bmem[10'h080 + i] = 8'h10;
    for (int i = 0; i < 17; i++) bmem[10'h030 + i] = 8'h10;
    bmem[10'h100] = 8'h60;
    bmem[10'h101] = 8'h12;
    bmem[10'h180] = 8'hC0;
    bmem[10'h190] = 8'h00;
    gen_random(64'h200, 14);

    // reset state, then irmovq/nop/halt from RESET_PC
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    push_test1();
    #1 rst_n = 1'b1;
    wait_drain("t1_drain", 200);
    check_val("t1_stop_state", W'(dbg_state), W'(1));
    expect_no_req("t1_stop_no_req", 10);

    // consumer stall with a full queue
    stall = 1'b1;
    redirect_to(64'h80);
    n = 0;
    while (!instr_valid && n < 50) begin @(negedge clk); n++; end
    check_val("t2_valid_seen", W'(instr_valid), W'(1));
    repeat (9) @(negedge clk);
    expect_no_req("t2_full_no_req", 5);
    stall = 1'b0;
    wait_drain("t2_drain", 400);

    // memory error beat at 0x40
    err_en   = 1'b1;
    err_addr = 64'h40;
    redirect_to(64'h30);
    wait_drain("t3_drain", 400);
    check_val("t3_stop_state", W'(dbg_state), W'(1));
    expect_no_req("t3_stop_no_req", 10);
    err_en = 1'b0;

    // invalid opcode, then halt
    redirect_raw(64'h180);
    exp_q.push_back(pack(2'd3, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h181));
    wait_drain("t4_ins_drain", 200);
    check_val("t4_ins_state", W'(dbg_state), W'(1));
    redirect_raw(64'h190);
    exp_q.push_back(pack(2'd1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h191));
    wait_drain("t4_hlt_drain", 200);
    expect_no_req("t4_hlt_no_req", 10);

    // random instruction mix crossing beat boundaries
    redirect_to(64'h200);
    wait_drain("rand_drain", 1500);

    // redirect while a response is outstanding
    extra_dly = 8;
    redirect_raw(64'h0);
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    check_val("t5_first_req", W'(mem_req), W'(1));
    extra_dly = 0;
    redirect_raw(64'h100);
    exp_q.push_back(pack(2'd0, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h102));
    exp_q.push_back(pack(2'd1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h103));
    n = 0;
    while (!mem_req && n < 60) begin @(negedge clk); n++; end
    check_val("t5_redir_addr", {W'(mem_req), mem_addr}, {W'(1), 64'h100});
    wait_drain("t5_drain", 300);

    // reset asserted mid-stream
    redirect_to(64'h80);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("t6_midrst");
    repeat (3) @(posedge clk);
    push_test1();
    #2 rst_n = 1'b1;
    wait_drain("t6_drain", 300);
    check_val("t6_stop_state", W'(dbg_state), W'(1));

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
